// File: rtl/wasm_pkg.sv
// Shared WebAssembly core types: memory bus payloads, traps and bulk-memory opcodes.
package wasm_pkg;

   localparam int unsigned PAGE_SIZE    = 65536;
   localparam int unsigned MEMORY_PAGES = 2;
   localparam int unsigned ADDR_W       = 32;
   localparam int unsigned DATA_W       = 32;

   typedef enum logic [1:0] {
      MEM_SIZE_1 = 2'd0,
      MEM_SIZE_2 = 2'd1,
      MEM_SIZE_4 = 2'd2,
      MEM_SIZE_8 = 2'd3
   } mem_size_t;

   typedef enum logic [3:0] {
      MEM_LOAD_I32   = 4'd0,
      MEM_LOAD_I64   = 4'd1,
      MEM_LOAD_I8_S  = 4'd2,
      MEM_LOAD_I8_U  = 4'd3,
      MEM_LOAD_I16_S = 4'd4,
      MEM_LOAD_I16_U = 4'd5,
      MEM_STORE_I32  = 4'd6,
      MEM_STORE_I8   = 4'd7
   } mem_op_t;

   typedef enum logic [2:0] {
      TRAP_NONE          = 3'd0,
      TRAP_UNREACHABLE   = 3'd1,
      TRAP_OUT_OF_BOUNDS = 3'd2,
      TRAP_DIV_ZERO      = 3'd3,
      TRAP_INT_OVERFLOW  = 3'd4
   } trap_t;

   typedef enum logic {
      BULK_FILL = 1'b0,
      BULK_COPY = 1'b1
   } bulk_op_t;

   typedef struct packed {
      logic              valid;
      logic              write;
      mem_size_t         size;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_bus_req_t;

   typedef struct packed {
      logic              ready;
      logic              rvalid;
      logic [DATA_W-1:0] rdata;
      logic              error;
   } mem_bus_resp_t;

endpackage

// File: rtl/wasm_bulk_mem_engine.sv
// Bulk memory engine for memory.fill / memory.copy: bounds-checks the request once,
// then walks linear memory one byte per bus transfer. busy_o selects this engine
// as the owner of the linear-memory bus in the enclosing top level.
module wasm_bulk_mem_engine
   import wasm_pkg::*;
#(
   parameter int unsigned MAX_PAGES = MEMORY_PAGES
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_i,
   input  bulk_op_t      op_i,
   input  logic [31:0]   dst_i,
   input  logic [31:0]   src_i,
   input  logic [31:0]   len_i,
   input  logic [31:0]   current_pages_i,
   output mem_bus_req_t  mem_req_o,
   output mem_op_t       mem_op_o,
   input  mem_bus_resp_t mem_resp_i,
   output logic          busy_o,
   output logic          done_o,
   output trap_t         trap_o
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CHECK   = 3'd1,
      ST_FILL    = 3'd2,
      ST_COPY_RD = 3'd3,
      ST_COPY_WR = 3'd4,
      ST_FINISH  = 3'd5
   } state_t;

   localparam int unsigned LIMIT_W = 49;

   state_t       r_state;
   bulk_op_t     r_op;
   logic [31:0]  r_dst;
   logic [31:0]  r_src;
   logic [31:0]  r_len;
   logic [31:0]  r_pages;
   logic [31:0]  r_offset;
   logic [31:0]  r_remaining;
   logic         r_desc;
   mem_bus_req_t r_req;
   mem_op_t      r_mem_op;
   logic         r_busy;
   logic         r_done;
   trap_t        r_trap;

   logic         w_dst_oob;
   logic         w_src_oob;
   logic         w_oob;
   logic         w_start_desc;
   logic [31:0]  w_start_off;
   logic [31:0]  w_off_next;
   logic         w_last;
   logic         w_unused_rdata;

   // End of [base, base+len) must not carry out of 32 bits nor pass the clamped memory size.
   function automatic logic oob(input logic [31:0] base, input logic [31:0] len,
                                input logic [31:0] pages);
      logic [32:0]        end_addr;
      logic [31:0]        eff_pages;
      logic [LIMIT_W-1:0] limit;
      end_addr  = {1'b0, base} + {1'b0, len};
      eff_pages = (pages > 32'(MAX_PAGES)) ? 32'(MAX_PAGES) : pages;
      limit     = LIMIT_W'(eff_pages) * LIMIT_W'(PAGE_SIZE);
      return end_addr[32] || (LIMIT_W'(end_addr) > limit);
   endfunction

   // Bounds verdict and walk setup, all from the latched request.
   assign w_dst_oob    = oob(r_dst, r_len, r_pages);
   assign w_src_oob    = (r_op == BULK_COPY) && oob(r_src, r_len, r_pages);
   assign w_oob        = w_dst_oob || w_src_oob;
   assign w_start_desc = (r_op == BULK_COPY) && (r_dst > r_src);
   assign w_start_off  = w_start_desc ? (r_len - 32'd1) : 32'd0;
   assign w_off_next   = r_desc ? (r_offset - 32'd1) : (r_offset + 32'd1);
   assign w_last       = (r_remaining == 32'd1);

   // Only the low byte of read data carries the copied value.
   assign w_unused_rdata = ^mem_resp_i.rdata[31:8];

   // Control FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_op        <= BULK_FILL;
         r_dst       <= '0;
         r_src       <= '0;
         r_len       <= '0;
         r_pages     <= '0;
         r_offset    <= '0;
         r_remaining <= '0;
         r_desc      <= 1'b0;
         r_req       <= '0;
         r_mem_op    <= MEM_LOAD_I8_U;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_trap      <= TRAP_NONE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               r_req  <= '0;
               if (start_i) begin
                  r_op    <= op_i;
                  r_dst   <= dst_i;
                  r_src   <= src_i;
                  r_len   <= len_i;
                  r_pages <= current_pages_i;
                  r_trap  <= TRAP_NONE;
                  r_busy  <= 1'b1;
                  r_state <= ST_CHECK;
               end
            end

            ST_CHECK: begin
               if (w_oob) begin
                  r_trap  <= TRAP_OUT_OF_BOUNDS;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (r_len == 32'd0) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_FINISH;
               end else begin
                  r_desc      <= w_start_desc;
                  r_offset    <= w_start_off;
                  r_remaining <= r_len;
                  r_req.valid <= 1'b1;
                  r_req.size  <= MEM_SIZE_1;
                  if (r_op == BULK_FILL) begin
                     r_req.write <= 1'b1;
                     r_req.addr  <= r_dst;
                     r_req.wdata <= {24'h0, r_src[7:0]};
                     r_state     <= ST_FILL;
                  end else begin
                     r_req.write <= 1'b0;
                     r_req.addr  <= r_src + w_start_off;
                     r_req.wdata <= '0;
                     r_mem_op    <= MEM_LOAD_I8_U;
                     r_state     <= ST_COPY_RD;
                  end
               end
            end

            ST_FILL: begin
               if (mem_resp_i.error) begin
                  r_req   <= '0;
                  r_trap  <= TRAP_OUT_OF_BOUNDS;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (mem_resp_i.ready) begin
                  r_remaining <= r_remaining - 32'd1;
                  if (w_last) begin
                     r_req   <= '0;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= ST_FINISH;
                  end else begin
                     r_offset   <= w_off_next;
                     r_req.addr <= r_dst + w_off_next;
                  end
               end
            end

            ST_COPY_RD: begin
               if (mem_resp_i.error) begin
                  r_req   <= '0;
                  r_trap  <= TRAP_OUT_OF_BOUNDS;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (mem_resp_i.ready && mem_resp_i.rvalid) begin
                  r_req.write <= 1'b1;
                  r_req.addr  <= r_dst + r_offset;
                  r_req.wdata <= {24'h0, mem_resp_i.rdata[7:0]};
                  r_state     <= ST_COPY_WR;
               end
            end

            ST_COPY_WR: begin
               if (mem_resp_i.error) begin
                  r_req   <= '0;
                  r_trap  <= TRAP_OUT_OF_BOUNDS;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (mem_resp_i.ready) begin
                  r_remaining <= r_remaining - 32'd1;
                  if (w_last) begin
                     r_req   <= '0;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= ST_FINISH;
                  end else begin
                     r_offset    <= w_off_next;
                     r_req.write <= 1'b0;
                     r_req.addr  <= r_src + w_off_next;
                     r_req.wdata <= '0;
                     r_mem_op    <= MEM_LOAD_I8_U;
                     r_state     <= ST_COPY_RD;
                  end
               end
            end

            ST_FINISH: begin
               r_done  <= 1'b0;
               r_req   <= '0;
               r_state <= ST_IDLE;
            end

            default: begin
               r_req   <= '0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Registered outputs straight to the ports.
   assign mem_req_o = r_req;
   assign mem_op_o  = r_mem_op;
   assign busy_o    = r_busy;
   assign done_o    = r_done;
   assign trap_o    = r_trap;

endmodule

// File: tb/tb_wasm_bulk_mem_engine.sv
// Scoreboard bench for the bulk memory engine with a byte-addressed memory model.
module tb_wasm_bulk_mem_engine;
   import wasm_pkg::*;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  data;
   } wr_t;

   typedef struct packed {
      trap_t       trap;
      logic [31:0] lat;
   } end_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_i = 1'b0;
   bulk_op_t      op_i = BULK_FILL;
   logic [31:0]   dst_i = '0;
   logic [31:0]   src_i = '0;
   logic [31:0]   len_i = '0;
   logic [31:0]   pages_i = '0;
   mem_bus_req_t  mem_req_o;
   mem_op_t       mem_op_o;
   mem_bus_resp_t mem_resp_i;
   logic          busy_o;
   logic          done_o;
   trap_t         trap_o;

   logic          r_ready = 1'b1;
   logic          r_err = 1'b0;
   logic [7:0]    tb_mem [0:65535];
   wr_t           exp_wr_q [$];
   end_t          exp_end_q [$];
   int            n_cmp = 0;
   int            n_mis = 0;
   int            req_cnt = 0;

   wasm_bulk_mem_engine dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start_i         (start_i),
      .op_i            (op_i),
      .dst_i           (dst_i),
      .src_i           (src_i),
      .len_i           (len_i),
      .current_pages_i (pages_i),
      .mem_req_o       (mem_req_o),
      .mem_op_o        (mem_op_o),
      .mem_resp_i      (mem_resp_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .trap_o          (trap_o)
   );

   always #5 clk = ~clk;

   // Zero-wait memory: read data returns in the cycle the request is accepted.
   always_comb begin
      mem_resp_i        = '0;
      mem_resp_i.ready  = r_ready;
      mem_resp_i.error  = r_err;
      mem_resp_i.rvalid = mem_req_o.valid && !mem_req_o.write && r_ready;
      mem_resp_i.rdata  = {24'h0, tb_mem[mem_req_o.addr[15:0]]};
   end

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bus monitor: counts requests, commits writes and pops the write scoreboard.
   always @(negedge clk) begin
      if (rst_n && mem_req_o.valid) begin
         req_cnt++;
         if (!mem_req_o.write)
            chk("rd_op", 96'(mem_op_o), 96'(MEM_LOAD_I8_U));
         if (mem_req_o.write && r_ready && !r_err) begin
            wr_t e;
            chk("wr_size", 96'(mem_req_o.size), 96'(MEM_SIZE_1));
            chk("wr_pending", 96'(exp_wr_q.size() != 0), 96'(1));
            if (exp_wr_q.size() != 0) begin
               e = exp_wr_q.pop_front();
               chk("wr_addr", 96'(mem_req_o.addr), 96'(e.addr));
               chk("wr_data", 96'(mem_req_o.wdata[7:0]), 96'(e.data));
            end
            tb_mem[mem_req_o.addr[15:0]] = mem_req_o.wdata[7:0];
         end
      end
   end

   // Expected write sequence from memmove semantics over the current memory image.
   task automatic push_exp(input bulk_op_t op, input logic [31:0] dst, input logic [31:0] src,
                           input logic [31:0] len, input int n_wr);
      wr_t         w;
      logic [31:0] i;
      logic [31:0] sa;
      for (int k = 0; k < n_wr; k++) begin
         if (op == BULK_FILL) begin
            w.addr = dst + 32'(k);
            w.data = src[7:0];
         end else begin
            i      = (dst > src) ? (len - 32'd1 - 32'(k)) : 32'(k);
            sa     = src + i;
            w.addr = dst + i;
            w.data = tb_mem[sa[15:0]];
         end
         exp_wr_q.push_back(w);
      end
   endtask

   task automatic run_op(input bulk_op_t op, input logic [31:0] dst, input logic [31:0] src,
                         input logic [31:0] len, input logic [31:0] pages,
                         input trap_t exp_trap, input int exp_lat, input int n_wr,
                         input int stall_at, input int stall_len, input int err_at,
                         input int ign_at);
      end_t         e;
      mem_bus_req_t held;
      int           n;
      int           req0;
      bit           fin;
      held = '0;
      fin  = 1'b0;
      n    = 0;
      @(posedge clk); #1;
      push_exp(op, dst, src, len, n_wr);
      e.trap = exp_trap;
      e.lat  = 32'(exp_lat);
      exp_end_q.push_back(e);
      req0    = req_cnt;
      op_i    = op;
      dst_i   = dst;
      src_i   = src;
      len_i   = len;
      pages_i = pages;
      start_i = 1'b1;
      while (!fin && n < 300) begin
         @(posedge clk); #1;
         n++;
         start_i = (n == ign_at);
         if (n == ign_at) begin
            op_i  = BULK_COPY;
            dst_i = 32'h100;
            src_i = 32'h0;
            len_i = 32'd1;
         end
         r_ready = !(stall_at != 0 && n >= stall_at && n < stall_at + stall_len);
         r_err   = (n == err_at);
         if (n == 1) begin
            chk("busy_on", 96'(busy_o), 96'(1));
            chk("trap_clr", 96'(trap_o), 96'(TRAP_NONE));
         end
         if (stall_at != 0 && n == stall_at)
            held = mem_req_o;
         if (stall_at != 0 && n > stall_at && n <= stall_at + stall_len)
            chk("stall_hold", 96'(mem_req_o), 96'(held));
         if (done_o || trap_o != TRAP_NONE) begin
            e = exp_end_q.pop_front();
            chk("end_trap", 96'(trap_o), 96'(e.trap));
            chk("latency", 96'(n), 96'(e.lat));
            fin = 1'b1;
         end
      end
      if (!fin) begin
         chk("timeout", 96'(n), 96'(exp_lat));
         exp_end_q.delete();
      end
      r_ready = 1'b1;
      r_err   = 1'b0;
      start_i = 1'b0;
      @(posedge clk); #1;
      chk("done_pulse", 96'(done_o), 96'(0));
      chk("busy_off", 96'(busy_o), 96'(0));
      chk("wr_left", 96'(exp_wr_q.size()), 96'(0));
      if (n_wr == 0 && stall_at == 0 && err_at == 0)
         chk("req_count", 96'(req_cnt - req0), 96'(0));
      exp_wr_q.delete();
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) tb_mem[a] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 96'(busy_o), 96'(0));
      chk("rst_done", 96'(done_o), 96'(0));
      chk("rst_trap", 96'(trap_o), 96'(TRAP_NONE));
      chk("rst_req", 96'(mem_req_o), 96'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Basic fill.
      run_op(BULK_FILL, 32'h10, 32'hAB, 32'd4, 32'd1, TRAP_NONE, 6, 4, 0, 0, 0, 0);
      for (int a = 16; a < 20; a++) chk("fill_mem", 96'(tb_mem[a]), 96'(8'hAB));
      chk("fill_edge", 96'(tb_mem[20]), 96'(8'h00));

      // Overlapping copy, dst > src: descending.
      for (int a = 0; a < 4; a++) tb_mem[a] = 8'(a + 1);
      run_op(BULK_COPY, 32'h2, 32'h0, 32'd4, 32'd1, TRAP_NONE, 10, 4, 0, 0, 0, 0);
      for (int a = 0; a < 4; a++) chk("copy_dn", 96'(tb_mem[a + 2]), 96'(a + 1));

      // Overlapping copy, dst < src: ascending.
      for (int a = 0; a < 4; a++) tb_mem[32 + a] = 8'(8'hA0 + a);
      run_op(BULK_COPY, 32'h20, 32'h21, 32'd3, 32'd1, TRAP_NONE, 8, 3, 0, 0, 0, 0);
      for (int a = 0; a < 3; a++) chk("copy_up", 96'(tb_mem[32 + a]), 96'(8'hA1 + a));

      // Bounds failures: past end of memory, 33-bit carry, clamp to MAX_PAGES.
      run_op(BULK_FILL, 32'hFFFE, 32'h55, 32'd4, 32'd1, TRAP_OUT_OF_BOUNDS, 2, 0, 0, 0, 0, 0);
      run_op(BULK_COPY, 32'hFFFF_FFFF, 32'h0, 32'd2, 32'd1, TRAP_OUT_OF_BOUNDS, 2, 0, 0, 0, 0, 0);
      run_op(BULK_FILL, 32'h1FFFF, 32'h11, 32'd2, 32'd100, TRAP_OUT_OF_BOUNDS, 2, 0, 0, 0, 0, 0);
      run_op(BULK_COPY, 32'h0, 32'h1FFFF, 32'd2, 32'd100, TRAP_OUT_OF_BOUNDS, 2, 0, 0, 0, 0, 0);

      // Zero length ending exactly at the limit, and a clamped in-bounds fill.
      run_op(BULK_FILL, 32'h10000, 32'h77, 32'd0, 32'd1, TRAP_NONE, 2, 0, 0, 0, 0, 0);
      run_op(BULK_FILL, 32'h1FFFE, 32'h66, 32'd2, 32'd100, TRAP_NONE, 4, 2, 0, 0, 0, 0);

      // Bus error on the third write: trap, earlier bytes stay written.
      run_op(BULK_FILL, 32'h40, 32'h5A, 32'd6, 32'd1, TRAP_OUT_OF_BOUNDS, 5, 2, 0, 0, 4, 0);
      chk("err_kept", 96'(tb_mem[16'h41]), 96'(8'h5A));
      chk("err_stop", 96'(tb_mem[16'h42]), 96'(8'h00));

      // Ready stall mid-fill plus a start pulse while busy.
      run_op(BULK_FILL, 32'h80, 32'h3C, 32'd6, 32'd1, TRAP_NONE, 11, 6, 4, 3, 0, 8);
      chk("ign_copy", 96'(tb_mem[16'h100]), 96'(8'h00));

      // Asynchronous reset in the middle of a copy.
      @(posedge clk); #1;
      push_exp(BULK_COPY, 32'h200, 32'h0, 32'd8, 8);
      op_i    = BULK_COPY;
      dst_i   = 32'h200;
      src_i   = 32'h0;
      len_i   = 32'd8;
      pages_i = 32'd1;
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk); #2;
      chk("pre_rst_busy", 96'(busy_o), 96'(1));
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 96'(busy_o), 96'(0));
      chk("arst_done", 96'(done_o), 96'(0));
      chk("arst_trap", 96'(trap_o), 96'(TRAP_NONE));
      chk("arst_req", 96'(mem_req_o), 96'(0));
      exp_wr_q.delete();
      @(negedge clk);
      rst_n = 1'b1;

      // Engine usable again after the abort.
      run_op(BULK_FILL, 32'h300, 32'hC3, 32'd1, 32'd1, TRAP_NONE, 3, 1, 0, 0, 0, 0);
      chk("post_rst", 96'(tb_mem[16'h300]), 96'(8'hC3));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/wasm_bulk_mem_engine.md
WASM_BULK_MEM_ENGINE -- requirements
Module: wasm_bulk_mem_engine

Interface
REQ-001 Parameter MAX_PAGES, default MEMORY_PAGES; page count used to clamp the bounds limit.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start_i  in  1  one-cycle request pulse; sampled only in IDLE.
REQ-005 op_i  in  bulk_op_t  BULK_FILL or BULK_COPY.
REQ-006 dst_i  in  32  destination byte address.
REQ-007 src_i  in  32  source address (copy); bits [7:0] are the fill byte (fill).
REQ-008 len_i  in  32  byte count.
REQ-009 current_pages_i  in  32  memory size in pages, from the memory management response.
REQ-010 mem_req_o  out  mem_bus_req_t  byte-wide bus request to linear memory.
REQ-011 mem_op_o  out  mem_op_t  MEM_LOAD_I8_U on reads, don't-care otherwise.
REQ-012 mem_resp_i  in  mem_bus_resp_t  ready, rvalid, rdata, error.
REQ-013 busy_o  out  1  high from the cycle after an accepted start until done or trap; bus owner select.
REQ-014 done_o  out  1  one-cycle pulse on successful completion.
REQ-015 trap_o  out  trap_t  held after a failure until the next accepted start; TRAP_NONE otherwise.

Function
REQ-016 States: IDLE, CHECK, FILL, COPY_RD, COPY_WR, FINISH.
REQ-017 IDLE + start_i: latch op, dst, src, len, current_pages_i; clear trap_o; go to CHECK.
REQ-018 start_i outside IDLE is ignored and has no side effects.
REQ-019 CHECK bounds rule: fail if {1'b0,dst}+len > min(pages,MAX_PAGES)*PAGE_SIZE.
REQ-020 Copy also fails if {1'b0,src}+len exceeds that limit.
REQ-021 All bounds sums are computed at 33 bits, and a carry into bit 32 counts as a failure.
REQ-022 On a bounds failure: trap_o = TRAP_OUT_OF_BOUNDS, go to IDLE, issue zero bus requests.
REQ-023 CHECK with len==0 and in bounds: go to FINISH with no bus traffic.
REQ-024 Copy direction: descending (offset len-1 down to 0) when dst > src; ascending otherwise.
REQ-025 FILL: each cycle with ready high, issue one write, size MEM_SIZE_1, wdata = fill byte, addr = dst+offset; decrement remaining.
REQ-026 COPY_RD: issue read of src+offset; when rvalid && ready, capture rdata[7:0] and go to COPY_WR.
REQ-027 COPY_WR: write the captured byte to dst+offset; then remaining--; go to COPY_RD, or FINISH if remaining==0.
REQ-028 Throughput: fill is 1 byte/cycle; copy is 2 cycles/byte.
REQ-029 Total latency from start is len+2 cycles (fill) and 2*len+2 cycles (copy).
REQ-030 ready low: hold the request stable and advance nothing.
REQ-031 mem_resp_i.error during any access: trap_o = TRAP_OUT_OF_BOUNDS, go to IDLE; bytes already written stay written.
REQ-032 FINISH: done_o=1 for one cycle, busy_o=0, return to IDLE.
REQ-033 mem_req_o.valid is asserted only in FILL, COPY_RD and COPY_WR; it is 0 in all other states.
REQ-034 Offset and remaining counters are 32-bit; no request is issued after remaining reaches 0.

Reset
REQ-035 Asynchronous assertion forces IDLE and sets: busy_o=0, done_o=0, trap_o=TRAP_NONE, mem_req_o all zero, counters 0.
REQ-036 Reset mid-operation aborts immediately; the partially written memory is left as is.

Structure
REQ-037 bulk_op_t {BULK_FILL, BULK_COPY} is added to wasm_pkg.
REQ-038 mem_bus_req_t, mem_bus_resp_t, mem_op_t, trap_t and PAGE_SIZE are reused from wasm_pkg.
REQ-039 Single module, no sub-modules; the bounds check is a local function.
REQ-040 Top level muxes memory bus ownership on busy_o.

Verification
REQ-041 Fill dst=0x10, val=0xAB, len=4, pages=1 -> bytes 0x10-0x13 = 0xAB; done_o pulses 6 cycles after start.
REQ-042 Copy src=0x0, dst=0x2, len=4 over bytes 01 02 03 04 -> 0x2..0x5 = 01 02 03 04 (descending direction verified); done_o after 10 cycles.
REQ-043 Fill dst=0xFFFE, len=4, pages=1 -> trap_o=TRAP_OUT_OF_BOUNDS; no write ever observed on the bus.
REQ-044 Copy dst=0xFFFFFFFF, len=2 -> 33-bit carry detected; trap raised; zero requests.
REQ-045 len=0 with dst=0x10000, pages=1 -> done_o with no bus traffic (end equals limit, in bounds).
REQ-046 Hold ready low for 3 cycles mid-fill, then start_i while busy, then rst_n low mid-copy -> request held stable during stall; second start ignored; reset outputs reached asynchronously.
